// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the LSU, one transaction in flight.
// Define ARB_ROUND_ROBIN_EN to alternate grants on ties instead of fixed LSU priority.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [63:0] ERR_DATA       = 64'hDEAD_BEEF_DEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [63:0] if_addr,
    output logic        if_resp_valid,
    output logic [63:0] if_rdata,

    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [63:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [63:0] lsu_wdata,
    input  logic [7:0]  lsu_wmask,
    output logic        lsu_resp_valid,
    output logic [63:0] lsu_rdata,

    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [63:0] mem_addr,
    output logic        mem_wen,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_resp_valid,
    input  logic [63:0] mem_rdata,

    output logic        busy,
    output logic        err
);

    localparam int unsigned CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic        OWN_IF  = 1'b0;
    localparam logic        OWN_LSU = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             state;
    state_t             next_state;
    logic               owner;
    logic [CNT_W-1:0]   cnt;
    logic               any_req;
    logic               grant;
    logic               grant_lsu;
    logic               timeout_hit;

`ifdef ARB_ROUND_ROBIN_EN
    logic               last_grant;
`endif

    assign any_req = if_req_valid | lsu_req_valid;
    assign grant   = (state == S_IDLE) & any_req;

    // A sole requester always wins; a tie goes to LSU unless round robin says otherwise.
    always_comb begin
        grant_lsu = lsu_req_valid;
`ifdef ARB_ROUND_ROBIN_EN
        if (if_req_valid && lsu_req_valid) begin
            grant_lsu = (last_grant == OWN_IF);
        end
`endif
    end

    assign timeout_hit = TO_EN && (state == S_RESP) && !mem_resp_valid
                         && (cnt == CNT_W'(TO_LAST));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (any_req) next_state = S_REQ;
            S_REQ:   if (mem_req_ready) next_state = S_RESP;
            S_RESP:  if (mem_resp_valid || timeout_hit) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Output logic; handshakes are suppressed while rst is asserted so nothing is half-accepted.
    always_comb begin
        if_req_ready   = 1'b0;
        lsu_req_ready  = 1'b0;
        if_resp_valid  = 1'b0;
        lsu_resp_valid = 1'b0;
        if_rdata       = mem_rdata;
        lsu_rdata      = mem_rdata;
        mem_req_valid  = 1'b0;
        busy           = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rst && any_req) begin
                    if_req_ready  = !grant_lsu;
                    lsu_req_ready = grant_lsu;
                end
            end
            S_REQ: begin
                mem_req_valid = 1'b1;
                busy          = 1'b1;
            end
            S_RESP: begin
                busy = 1'b1;
                if (!rst && (mem_resp_valid || timeout_hit)) begin
                    if_resp_valid  = (owner == OWN_IF);
                    lsu_resp_valid = (owner == OWN_LSU);
                end
                if (timeout_hit) begin
                    if_rdata  = ERR_DATA;
                    lsu_rdata = ERR_DATA;
                end else if (mem_wen) begin
                    lsu_rdata = '0;
                end
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Latched request, response timer and sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            owner     <= OWN_IF;
            mem_addr  <= '0;
            mem_wen   <= 1'b0;
            mem_wdata <= '0;
            mem_wmask <= '0;
            cnt       <= '0;
            err       <= 1'b0;
        end else begin
            if (grant) begin
                owner     <= grant_lsu;
                mem_addr  <= grant_lsu ? lsu_addr : if_addr;
                mem_wen   <= grant_lsu & lsu_wen;
                mem_wdata <= grant_lsu ? lsu_wdata : '0;
                mem_wmask <= (grant_lsu && lsu_wen) ? lsu_wmask : '0;
            end
            if (state == S_REQ && mem_req_ready) begin
                cnt <= '0;
            end else if (TO_EN && state == S_RESP && !mem_resp_valid) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (timeout_hit || (mem_resp_valid && state != S_RESP)) begin
                err <= 1'b1;
            end
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Remembers the most recent winner for tie-breaking
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= OWN_LSU;
        end else if (grant) begin
            last_grant <= grant_lsu;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level arbitration/memory model.
// Builds for both arbitration modes (ARB_ROUND_ROBIN_EN defined or not).
module tb_mem_port_arbiter;

    localparam int unsigned TO  = 4;
    localparam logic [63:0] ERR = 64'hDEAD_BEEF_DEAD_BEEF;

    logic        clk;
    logic        rst;
    logic        if_req_valid, if_req_ready, if_resp_valid;
    logic [63:0] if_addr, if_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
    logic [63:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [7:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;
    logic        busy, err;

    mem_port_arbiter #(.TIMEOUT_CYCLES(TO), .ERR_DATA(ERR)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks;
    int n_errors;

    // Pending requester state: a requester holds its fields until it is granted.
    logic        if_pend, lsu_pend;
    logic [63:0] if_a, lsu_a, lsu_wd;
    logic        lsu_we;
    logic [7:0]  lsu_wm;
    logic        m_last_lsu;
    logic        exp_err;
    logic        grants[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    // Arbitration rule: sole requester wins; tie goes to LSU or alternates with round robin.
    function automatic logic pick_lsu(input logic ifv, input logic lsuv);
        if (!ifv) return 1'b1;
        if (!lsuv) return 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        return !m_last_lsu;
`else
        return 1'b1;
`endif
    endfunction

    task automatic drive_reqs();
        if_req_valid  = if_pend;
        if_addr       = if_a;
        lsu_req_valid = lsu_pend;
        lsu_addr      = lsu_a;
        lsu_wen       = lsu_we;
        lsu_wdata     = lsu_wd;
        lsu_wmask     = lsu_wm;
    endtask

    task automatic new_if();
        if_pend = 1'b1;
        if_a    = rand64();
    endtask

    task automatic new_lsu();
        lsu_pend = 1'b1;
        lsu_a    = rand64();
        lsu_we   = 1'($urandom);
        lsu_wd   = rand64();
        lsu_wm   = 8'($urandom);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        if_pend = 1'b0; lsu_pend = 1'b0;
        drive_reqs();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_last_lsu = 1'b1;
        exp_err = 1'b0;
        grants.delete();
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_req_valid", mem_req_valid, 0);
        check_eq("rst_addr", mem_addr, 0);
        check_eq("rst_wen", mem_wen, 0);
        check_eq("rst_wdata", mem_wdata, 0);
        check_eq("rst_wmask", mem_wmask, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_ready", {if_req_ready, lsu_req_ready}, 0);
        check_eq("rst_resp", {if_resp_valid, lsu_resp_valid}, 0);
    endtask

    // One transaction: grant, rdy_dly stall cycles in REQ, response after rsp_dly RESP cycles
    // (a delay >= TO means memory never answers). rst_at >= 0 asserts rst in that RESP cycle.
    task automatic run_txn(input int rdy_dly, input int rsp_dly, input logic [63:0] rd,
                           input int rst_at, output int cycles);
        logic        win_lsu, e_we, hit, tmo;
        logic [63:0] e_addr, e_wd, e_rd;
        logic [7:0]  e_wm;
        @(negedge clk);
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        drive_reqs();
        #1;
        check_eq("err", err, exp_err);
        check_eq("busy_idle", busy, 0);
        win_lsu = pick_lsu(if_pend, lsu_pend);
        check_eq("if_ready", if_req_ready, !win_lsu);
        check_eq("lsu_ready", lsu_req_ready, win_lsu);
        grants.push_back(win_lsu);
        m_last_lsu = win_lsu;
        e_addr = win_lsu ? lsu_a : if_a;
        e_we   = win_lsu && lsu_we;
        e_wd   = lsu_wd;
        e_wm   = e_we ? lsu_wm : 8'h00;
        if (win_lsu) lsu_pend = 1'b0; else if_pend = 1'b0;
        cycles = 1;

        for (int k = 0; k <= rdy_dly; k++) begin
            @(negedge clk);
            drive_reqs();
            mem_req_ready = (k == rdy_dly);
            #1;
            check_eq("req_valid", mem_req_valid, 1);
            check_eq("mem_addr", mem_addr, e_addr);
            check_eq("mem_wen", mem_wen, e_we);
            if (e_we) check_eq("mem_wdata", mem_wdata, e_wd);
            check_eq("mem_wmask", mem_wmask, e_wm);
            check_eq("busy_req", busy, 1);
            check_eq("ready_in_req", {if_req_ready, lsu_req_ready}, 0);
            cycles++;
        end

        for (int k = 0; k < int'(TO); k++) begin
            @(negedge clk);
            drive_reqs();
            mem_req_ready = 1'b0;
            hit = (k == rsp_dly);
            if (k == rst_at) begin
                rst = 1'b1;
                hit = 1'b0;
            end
            mem_resp_valid = hit;
            mem_rdata = rd;
            #1;
            check_eq("req_valid_resp", mem_req_valid, 0);
            if (k == rst_at) begin
                check_eq("resp_in_rst", {if_resp_valid, lsu_resp_valid}, 0);
                cycles++;
                break;
            end
            tmo = !hit && (k == int'(TO) - 1);
            check_eq("if_resp", if_resp_valid, (hit || tmo) && !win_lsu);
            check_eq("lsu_resp", lsu_resp_valid, (hit || tmo) && win_lsu);
            if (hit || tmo) begin
                e_rd = tmo ? ERR : (e_we ? 64'h0 : rd);
                if (win_lsu) check_eq("lsu_rdata", lsu_rdata, e_rd);
                else check_eq("if_rdata", if_rdata, e_rd);
            end
            if (tmo) exp_err = 1'b1;
            cycles++;
            if (hit || tmo) break;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        logic exp_ord[4];
        n_checks = 0; n_errors = 0;
        clk = 1'b0; rst = 1'b1;
        if_pend = 1'b0; lsu_pend = 1'b0;
        if_a = '0; lsu_a = '0; lsu_we = 1'b0; lsu_wd = '0; lsu_wm = '0;
        drive_reqs();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
        do_reset();

        // Single IF read, memory answers immediately: three cycles end to end.
        if_pend = 1'b1; if_a = 64'h0000_0000_8000_0000;
        run_txn(0, 0, 64'h0000_0000_0000_0013, -1, cyc);
        check_eq("txn_cycles", cyc, 3);

        // LSU full-mask write with a two-cycle port stall.
        lsu_pend = 1'b1; lsu_a = 64'h0000_0000_8000_1000; lsu_we = 1'b1;
        lsu_wd = 64'h1122_3344_5566_7788; lsu_wm = 8'hFF;
        run_txn(2, 0, 64'hFFFF_0000_FFFF_0000, -1, cyc);

        // Both requesters continuously valid from reset.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (!if_pend) new_if();
            if (!lsu_pend) new_lsu();
            run_txn(0, 0, rand64(), -1, cyc);
        end
`ifdef ARB_ROUND_ROBIN_EN
        exp_ord = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_ord = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        for (int i = 0; i < 4; i++) check_eq($sformatf("grant_order%0d", i), grants[i], exp_ord[i]);

        // Dead memory: timeout on the 4th RESP cycle, then a normal LSU read.
        do_reset();
        if_pend = 1'b1; if_a = 64'h0000_0000_8000_0040;
        run_txn(0, 99, 64'h0, -1, cyc);
        lsu_pend = 1'b1; lsu_a = 64'h0000_0000_8000_2000; lsu_we = 1'b0;
        lsu_wd = rand64(); lsu_wm = 8'h0F;
        run_txn(1, 1, 64'hCAFE_F00D_0123_4567, -1, cyc);
        @(negedge clk);
        mem_resp_valid = 1'b0;
        drive_reqs();
        #1;
        check_eq("err_sticky", err, 1);
        check_eq("busy_after_to", busy, 0);

        // Spurious response while idle.
        do_reset();
        @(negedge clk);
        mem_resp_valid = 1'b1; mem_rdata = rand64();
        #1;
        check_eq("spur_resp", {if_resp_valid, lsu_resp_valid}, 0);
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1;
        check_eq("spur_err", err, 1);

        // Reset during RESP abandons the transaction; a late response is not routed.
        do_reset();
        if_pend = 1'b1; if_a = 64'h0000_0000_8000_0080;
        run_txn(0, 99, 64'h0, 1, cyc);
        @(negedge clk);
        rst = 1'b0;
        mem_resp_valid = 1'b1; mem_rdata = rand64();
        drive_reqs();
        #1;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_req_valid", mem_req_valid, 0);
        check_eq("late_resp", {if_resp_valid, lsu_resp_valid}, 0);
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1;
        check_eq("late_err", err, 1);

        // Random traffic with random stalls, response delays and timeouts.
        do_reset();
        for (int t = 0; t < 150; t++) begin
            if (!if_pend && !lsu_pend && ($urandom % 4 == 0)) begin
                @(negedge clk);
                mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
                drive_reqs();
                #1;
                check_eq("idle_ready", {if_req_ready, lsu_req_ready}, 0);
                check_eq("idle_busy", busy, 0);
            end
            if (!if_pend && ($urandom % 2 == 1)) new_if();
            if (!lsu_pend && ($urandom % 2 == 1)) new_lsu();
            if (!if_pend && !lsu_pend) begin
                if ($urandom % 2 == 1) new_if(); else new_lsu();
            end
            run_txn(int'($urandom % 3), int'($urandom % 6), rand64(), -1, cyc);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
